// File: rtl/mips_pkg.sv
// Shared MIPS core definitions used by the MEM/WB stage: load-type codes,
// register/data widths and the sign/zero extension helpers.
package mips_pkg;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef enum logic [2:0] {
        LT_LW  = 3'b000,
        LT_LB  = 3'b001,
        LT_LBU = 3'b010,
        LT_LH  = 3'b011,
        LT_LHU = 3'b100
    } load_type_t;

    typedef struct packed {
        logic                valid;
        logic                reg_write;
        logic                mem_to_reg;
        logic                link;
        load_type_t          load_type;
        logic [REG_W-1:0]    rd;
        logic [DATA_W-1:0]   alu_result;
        logic [DATA_W-1:0]   mem_rdata;
        logic [DATA_W-1:0]   pc_plus8;
    } wb_stage_t;

    function automatic logic [DATA_W-1:0] extendByte(input logic [7:0] b, input logic isSigned);
        return {{(DATA_W-8){isSigned & b[7]}}, b};
    endfunction

    function automatic logic [DATA_W-1:0] extendHalf(input logic [15:0] h, input logic isSigned);
        return {{(DATA_W-16){isSigned & h[15]}}, h};
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// MEM -> WB bundle, ID bypass query and register-file write port of the
// writeback stage. The master side is the pipeline around the stage.
interface mem_wb_stage_if;
    import mips_pkg::*;

    logic                stall;
    logic                flush;
    logic                in_valid;
    logic                in_reg_write;
    logic                in_mem_to_reg;
    logic                in_link;
    logic [2:0]          in_load_type;
    logic [REG_W-1:0]    in_rd;
    logic [DATA_W-1:0]   in_alu_result;
    logic [DATA_W-1:0]   in_mem_rdata;
    logic [DATA_W-1:0]   in_pc_plus8;
    logic [REG_W-1:0]    id_rs;
    logic [REG_W-1:0]    id_rt;

    logic                RegWrite;
    logic [REG_W-1:0]    Rd;
    logic [DATA_W-1:0]   data;
    logic                wb_valid;
    logic                rs_hit;
    logic                rt_hit;
    logic [31:0]         retire_count;

    modport master (
        output stall, flush, in_valid, in_reg_write, in_mem_to_reg, in_link,
               in_load_type, in_rd, in_alu_result, in_mem_rdata, in_pc_plus8,
               id_rs, id_rt,
        input  RegWrite, Rd, data, wb_valid, rs_hit, rt_hit, retire_count
    );

    modport slave (
        input  stall, flush, in_valid, in_reg_write, in_mem_to_reg, in_link,
               in_load_type, in_rd, in_alu_result, in_mem_rdata, in_pc_plus8,
               id_rs, id_rt,
        output RegWrite, Rd, data, wb_valid, rs_hit, rt_hit, retire_count
    );

endinterface

// File: rtl/load_extract.sv
// Big-endian load data extraction: picks the addressed byte/halfword out of
// the raw memory word and sign- or zero-extends it to 32 bits.
module load_extract
    import mips_pkg::*;
(
    input  logic [DATA_W-1:0] word_i,
    input  logic [1:0]        offset_i,
    input  load_type_t        load_type_i,
    output logic [DATA_W-1:0] data_o
);

    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Offset 0 is the most significant byte (big-endian lane order).
    always_comb begin
        byteSel = word_i[31:24];
        case (offset_i)
            2'd0:    byteSel = word_i[31:24];
            2'd1:    byteSel = word_i[23:16];
            2'd2:    byteSel = word_i[15:8];
            default: byteSel = word_i[7:0];
        endcase
    end

    always_comb begin
        halfSel = offset_i[1] ? word_i[15:0] : word_i[31:16];
    end

    // Unused codes fall through to the full word.
    always_comb begin
        data_o = word_i;
        case (load_type_i)
            LT_LB:   data_o = extendByte(byteSel, 1'b1);
            LT_LBU:  data_o = extendByte(byteSel, 1'b0);
            LT_LH:   data_o = extendHalf(halfSel, 1'b1);
            LT_LHU:  data_o = extendHalf(halfSel, 1'b0);
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage: drives the register file
// write port, flags WB->ID bypass hits and counts retired instructions.
module mem_wb_stage
    import mips_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    mem_wb_stage_if.slave   bus
);

    wb_stage_t          stage_q, stage_d;
    logic [31:0]        retireCount_q, retireCount_d;
    logic [DATA_W-1:0]  loadData;
    logic [DATA_W-1:0]  wbData;
    logic               regWrite;

    // Flush beats stall; a flushed slot is a fully cleared bubble.
    always_comb begin
        stage_d = stage_q;
        if (bus.flush) begin
            stage_d = '0;
        end else if (!bus.stall) begin
            stage_d.valid      = bus.in_valid;
            stage_d.reg_write  = bus.in_reg_write;
            stage_d.mem_to_reg = bus.in_mem_to_reg;
            stage_d.link       = bus.in_link;
            stage_d.load_type  = load_type_t'(bus.in_load_type);
            stage_d.rd         = bus.in_rd;
            stage_d.alu_result = bus.in_alu_result;
            stage_d.mem_rdata  = bus.in_mem_rdata;
            stage_d.pc_plus8   = bus.in_pc_plus8;
        end
    end

    // An instruction retires on the edge it leaves WB, so a held one counts once.
    always_comb begin
        retireCount_d = retireCount_q;
        if (stage_q.valid && !bus.stall) begin
            retireCount_d = retireCount_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q       <= '0;
            retireCount_q <= '0;
        end else begin
            stage_q       <= stage_d;
            retireCount_q <= retireCount_d;
        end
    end

    load_extract u_loadExtract (
        .word_i      (stage_q.mem_rdata),
        .offset_i    (stage_q.alu_result[1:0]),
        .load_type_i (stage_q.load_type),
        .data_o      (loadData)
    );

    always_comb begin
        if (stage_q.link) begin
            wbData = stage_q.pc_plus8;
        end else if (stage_q.mem_to_reg) begin
            wbData = loadData;
        end else begin
            wbData = stage_q.alu_result;
        end
    end

    // Writes to $zero are dropped here, which also keeps the bypass from firing on r0.
    always_comb begin
        regWrite = stage_q.valid & stage_q.reg_write & (stage_q.rd != REG_ZERO);
    end

    assign bus.RegWrite     = regWrite;
    assign bus.Rd           = stage_q.rd;
    assign bus.data         = wbData;
    assign bus.wb_valid     = stage_q.valid;
    assign bus.rs_hit       = regWrite & (bus.id_rs == stage_q.rd);
    assign bus.rt_hit       = regWrite & (bus.id_rt == stage_q.rd);
    assign bus.retire_count = retireCount_q;

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

MEM/WB pipeline register and writeback stage of the pipelined MIPS core. Captures the MEM-stage result bundle, extracts and extends load data, selects the writeback value, and drives the register file write port (`RegWrite`, `Rd`, `data`). It also flags WB→ID bypass hits, because a register-file write lands one edge after the ID stage's asynchronous read. A retired-instruction counter is included for debug.

## Interface
Parameters:
- none; widths fixed by the ISA (32-bit data, 5-bit register index).

Ports:
- `clk`  in  1  core clock; all state updates on posedge
- `rst`  in  1  synchronous, active-high reset
- `stall`  in  1  hold stage contents
- `flush`  in  1  replace incoming instruction with a bubble
- `in_valid`  in  1  MEM stage holds a real instruction
- `in_reg_write`  in  1  instruction writes a GPR
- `in_mem_to_reg`  in  1  writeback source is load data
- `in_link`  in  1  writeback source is PC+8 (jal/jalr)
- `in_load_type`  in  3  load width/sign code
- `in_rd`  in  5  destination register
- `in_alu_result`  in  32  ALU result / effective address
- `in_mem_rdata`  in  32  raw data-memory word
- `in_pc_plus8`  in  32  link address
- `id_rs`, `id_rt`  in  5 each  source indices being read in ID
- `RegWrite`  out  1  register file write enable
- `Rd`  out  5  register file write index
- `data`  out  32  register file write data
- `wb_valid`  out  1  WB holds a real instruction
- `rs_hit`, `rt_hit`  out  1 each  ID source must take `data` instead of regfile output
- `retire_count`  out  32  retired instructions

## Operation
- Stage register fields: valid, reg_write, mem_to_reg, link, load_type, rd, alu_result, mem_rdata, pc_plus8.
- Update on each posedge, evaluated in priority order:
  - `rst`: all fields are cleared to 0.
  - `flush`: valid ← 0. Other fields are don't-care but are cleared.
  - `stall`: all fields hold.
  - Otherwise: all fields load from the `in_*` inputs.
- `flush` and `stall` asserted together: `flush` wins.
- Load extraction uses the registered mem_rdata, big-endian, with byte offset a = alu_result[1:0]:
  - LW (000): the full word.
  - LB (001) / LBU (010): byte a (a=0 → bits 31:24, a=3 → bits 7:0), sign- or zero-extended.
  - LH (011) / LHU (100): a[1]=0 → bits 31:16, a[1]=1 → bits 15:0, sign- or zero-extended. a[0] is ignored.
  - Codes 101–111 behave as LW.
- Writeback select: link ? pc_plus8 : (mem_to_reg ? load_data : alu_result). link has priority over mem_to_reg.
- `RegWrite` = valid & reg_write & (rd != 0). Writes to $zero are suppressed here.
- `Rd` = rd. `data` = selected value.
- `wb_valid` = valid.
- `rs_hit` = RegWrite & (id_rs == rd). `rt_hit` = RegWrite & (id_rt == rd). Never asserted for index 0.
- Retire counter:
  - Increments on a posedge where valid=1, stall=0 and rst=0.
  - Counts every valid instruction, including those that do not write a GPR.
  - Wraps from 0xFFFFFFFF to 0.
  - A held instruction is counted exactly once.

## Timing
- Latency: MEM inputs sampled at edge N appear on `RegWrite`/`Rd`/`data` in cycle N..N+1. The register file commits at edge N+1.
- All outputs are combinational functions of the stage registers and `id_rs`/`id_rt`. No input-to-output combinational path exists except `id_rs`/`id_rt` → hit flags.
- Reset values: `RegWrite`=0, `Rd`=0, `data`=0, `wb_valid`=0, `rs_hit`=`rt_hit`=0, `retire_count`=0.
- During stall, `RegWrite` stays asserted and the same value is rewritten each cycle. This is idempotent and required behaviour.
- Reset mid-stall or mid-flush: reset wins and the bubble state results.

## Structure
- Shared package `mips_pkg`:
  - Load-type codes: LT_LW, LT_LB, LT_LBU, LT_LH, LT_LHU.
  - REG_ZERO = 5'd0.
  - Data width constant (32).
- Sub-module `load_extract`: combinational; inputs word, offset[1:0] and load_type; output 32-bit extended value. Testable in isolation.
- Stage register, writeback mux, hit compare and counter live in `mem_wb_stage`.

## Test plan
- Reset, then ALU write: in_valid=1, reg_write=1, rd=8, alu_result=0x1234 → next cycle `RegWrite`=1, `Rd`=8, `data`=0x1234. Before that edge, all outputs are 0.
- Loads with mem_rdata=0x80FF7F01:
  - LB, a=0 → 0xFFFFFF80
  - LBU, a=0 → 0x00000080
  - LB, a=2 → 0x0000007F
  - LH, a=2 → 0x00007F01
  - LHU, a=0 → 0x000080FF
  - LW → 0x80FF7F01
- Link priority: jal with link=1, mem_to_reg=1, rd=31, pc_plus8=0x00400010 → `data`=0x00400010, `RegWrite`=1.
- $zero and bypass: rd=0, reg_write=1 → `RegWrite`=0, `rs_hit`=0 with id_rs=0. Then rd=9 with id_rs=9, id_rt=10 → `rs_hit`=1, `rt_hit`=0.
- Stall/flush: load instruction, then 3 cycles of stall → outputs hold and `retire_count` rises by exactly 1 after release. `stall`+`flush` together → `wb_valid`=0 and `RegWrite`=0 next cycle.
- Counter wrap: force 0xFFFFFFFE, retire 3 instructions → `retire_count`=1.
